// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the multi-cycle execution controller: state codes,
// instruction width, default halt opcode and the saturating increment.
package exec_ctrl_pkg;

  localparam int INSTR_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_EXEC  = 3'd2;
  localparam state_t S_MEM   = 3'd3;
  localparam state_t S_WB    = 3'd4;
  localparam state_t S_HALT  = 3'd5;

  localparam logic [INSTR_W-1:0] HALT_OPCODE_DEF = 16'hFFFF;

  // Counters up to 32 bits share this; the caller passes its own all-ones limit.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Bundle between the execution controller and the decoder/datapath/debug side.
// master = exec_ctrl, slave = the surrounding core and debug logic.
interface exec_ctrl_if
  import exec_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic               run;
  logic               step;
  logic               halt_req;
  logic [INSTR_W-1:0] op;
  logic               dec_pcwe;
  logic               dec_regwe;
  logic               dec_memwe;
  logic [INSTR_W-1:0] ir;
  logic               pcwe;
  logic               pcinc;
  logic               regwe;
  logic               memwe;
  logic               zfwe;
  logic               busy;
  logic               halted;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   instr_cnt;

  modport master (
    input  run, step, halt_req, op, dec_pcwe, dec_regwe, dec_memwe,
    output ir, pcwe, pcinc, regwe, memwe, zfwe, busy, halted, cycle_cnt, instr_cnt
  );

  modport slave (
    output run, step, halt_req, op, dec_pcwe, dec_regwe, dec_memwe,
    input  ir, pcwe, pcinc, regwe, memwe, zfwe, busy, halted, cycle_cnt, instr_cnt
  );

endinterface

// File: rtl/exec_ctrl_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import exec_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [31:0] MAX_V = 32'({CNT_W{1'b1}});

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = CNT_W'(sat_inc(32'(cnt_q), MAX_V));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle sequencer: latches the instruction, qualifies decoder write
// enables by phase, and provides run/step/halt debug control plus counters.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int                 MEM_WAIT    = 2,
  parameter int                 CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  exec_ctrl_if.master  bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0]         wait_q, wait_d;
  logic               step_flag_q, step_flag_d;
  logic               halt_pend_q, halt_pend_d;
  logic               busy;
  logic               in_wb;

  assign busy  = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                 (state_q == S_MEM)   || (state_q == S_WB);
  assign in_wb = (state_q == S_WB);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    wait_d      = wait_q;
    step_flag_d = step_flag_q;
    halt_pend_d = halt_pend_q;
    if (busy) halt_pend_d = halt_pend_q | bus.halt_req;
    case (state_q)
      S_IDLE: begin
        if (bus.step) begin
          state_d     = S_FETCH;
          step_flag_d = 1'b1;
        end else if (bus.run) begin
          state_d     = S_FETCH;
          step_flag_d = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = bus.op;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ir_q == HALT_OPCODE) begin
          state_d = S_HALT;
        end else if (bus.dec_memwe) begin
          state_d = S_MEM;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (wait_q == 4'd0) state_d = S_WB;
        else                wait_d  = wait_q - 4'd1;
      end
      S_WB: begin
        // A halt_req landing in WB itself still stops at this boundary.
        if (halt_pend_q || bus.halt_req || step_flag_q) begin
          state_d     = S_IDLE;
          step_flag_d = 1'b0;
          halt_pend_d = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      wait_q      <= '0;
      step_flag_q <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      wait_q      <= wait_d;
      step_flag_q <= step_flag_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Strobes decode only registered state, so run/step never reach them.
  assign bus.ir     = ir_q;
  assign bus.zfwe   = (state_q == S_EXEC) && (ir_q != HALT_OPCODE);
  assign bus.memwe  = (state_q == S_MEM) && (wait_q == 4'd0);
  assign bus.regwe  = in_wb && bus.dec_regwe;
  assign bus.pcwe   = in_wb && bus.dec_pcwe;
  assign bus.pcinc  = in_wb && !bus.dec_pcwe;
  assign bus.busy   = busy;
  assign bus.halted = (state_q == S_HALT);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (busy),
    .clear_i (1'b0),
    .cnt_o   (bus.cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (in_wb),
    .clear_i (1'b0),
    .cnt_o   (bus.instr_cnt)
  );

endmodule

// File: tb/tb_exec_ctrl.sv
// Scenario bench for exec_ctrl: retirement records are queued when an
// instruction is issued and popped/compared when the DUT reaches WB.
module tb_exec_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  exec_ctrl_if #(.CNT_W(6)) bus ();

  exec_ctrl #(.HALT_OPCODE(16'hFFFF), .MEM_WAIT(2), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] ir;
    logic        regwe;
    logic        pcwe;
    logic        pcinc;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic idle_inputs();
    bus.run = 1'b0; bus.step = 1'b0; bus.halt_req = 1'b0;
    bus.op = 16'h0000; bus.dec_pcwe = 1'b0; bus.dec_regwe = 1'b0; bus.dec_memwe = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input logic [15:0] ir, input logic regwe, input logic pcwe);
    exp_t e;
    e.ir = ir; e.regwe = regwe; e.pcwe = pcwe; e.pcinc = ~pcwe;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    bus.run = 1'b1;
    @(negedge clk);
    compared++;
    if ({bus.busy, bus.halted} !== 2'b00) begin
      mismatched++; $display("FAIL reset_status: busy/halted=%b required 00", {bus.busy, bus.halted});
    end
    compared++;
    if ({bus.pcwe, bus.pcinc, bus.regwe, bus.memwe, bus.zfwe} !== 5'b0) begin
      mismatched++; $display("FAIL reset_strobes: got %b required 00000",
                             {bus.pcwe, bus.pcinc, bus.regwe, bus.memwe, bus.zfwe});
    end
    compared++;
    if ({bus.ir, bus.cycle_cnt, bus.instr_cnt} !== 28'h0) begin
      mismatched++; $display("FAIL reset_regs: ir=%h cyc=%0d ins=%0d required 0", bus.ir, bus.cycle_cnt, bus.instr_cnt);
    end
    bus.run = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic test_run_single();
    exp_t e;
    do_reset();
    bus.op = 16'h1234; bus.dec_regwe = 1'b1; bus.dec_pcwe = 1'b0; bus.run = 1'b1;
    push_exp(16'h1234, 1'b1, 1'b0);
    @(negedge clk); // cycle 1: FETCH
    bus.run = 1'b0;
    compared++;
    if ({bus.busy, bus.ir, bus.regwe, bus.pcinc} !== {1'b1, 16'h0000, 2'b00}) begin
      mismatched++; $display("FAIL run_c1: busy=%b ir=%h regwe=%b pcinc=%b required 1 0000 0 0",
                             bus.busy, bus.ir, bus.regwe, bus.pcinc);
    end
    @(negedge clk); // cycle 2: EXEC
    compared++;
    if ({bus.ir, bus.zfwe, bus.regwe, bus.pcinc} !== {16'h1234, 3'b100}) begin
      mismatched++; $display("FAIL run_c2: ir=%h zfwe=%b regwe=%b pcinc=%b required 1234 1 0 0",
                             bus.ir, bus.zfwe, bus.regwe, bus.pcinc);
    end
    @(negedge clk); // cycle 3: WB
    compared++;
    if (sb.size() == 0) begin
      mismatched++; $display("FAIL run_wb: scoreboard empty at WB");
    end else begin
      e = sb.pop_front();
      if ({bus.ir, bus.regwe, bus.pcwe, bus.pcinc, bus.instr_cnt} !== {e.ir, e.regwe, e.pcwe, e.pcinc, 6'd0}) begin
        mismatched++; $display("FAIL run_wb: ir=%h regwe=%b pcwe=%b pcinc=%b ins=%0d required %h %b %b %b 0",
                               bus.ir, bus.regwe, bus.pcwe, bus.pcinc, bus.instr_cnt, e.ir, e.regwe, e.pcwe, e.pcinc);
      end
    end
    @(negedge clk); // cycle 4: next FETCH
    compared++;
    if ({bus.busy, bus.instr_cnt, bus.regwe, bus.pcinc} !== {1'b1, 6'd1, 2'b00}) begin
      mismatched++; $display("FAIL run_c4: busy=%b ins=%0d regwe=%b pcinc=%b required 1 1 0 0",
                             bus.busy, bus.instr_cnt, bus.regwe, bus.pcinc);
    end
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
    push_exp(16'h1234, 1'b1, 1'b0);
    @(negedge clk); // WB of second instruction
    if (sb.size() != 0) e = sb.pop_front();
    @(negedge clk);
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL run_stop: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_step_mem();
    exp_t e;
    int cyc = 0, mem_n = 0, mem_pos = 0, wb_pos = 0;
    do_reset();
    bus.op = 16'h00A5; bus.dec_memwe = 1'b1; bus.dec_regwe = 1'b0; bus.dec_pcwe = 1'b0;
    bus.step = 1'b1; bus.run = 1'b1;
    push_exp(16'h00A5, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        cyc++;
        bus.step = 1'b0; bus.run = 1'b0;
        if (bus.memwe) begin mem_n++; mem_pos = cyc; end
        if (bus.pcinc || bus.pcwe) begin
          wb_pos = cyc;
          compared++;
          if (sb.size() == 0) begin
            mismatched++; $display("FAIL mem_wb: scoreboard empty at WB");
          end else begin
            e = sb.pop_front();
            if ({bus.ir, bus.regwe, bus.pcwe, bus.pcinc} !== {e.ir, e.regwe, e.pcwe, e.pcinc}) begin
              mismatched++; $display("FAIL mem_wb: ir=%h regwe=%b pcwe=%b pcinc=%b required %h %b %b %b",
                                     bus.ir, bus.regwe, bus.pcwe, bus.pcinc, e.ir, e.regwe, e.pcwe, e.pcinc);
            end
          end
        end
      end else if (cyc > 0) begin
        break;
      end
    end
    compared++;
    if ({cyc, mem_n, mem_pos, wb_pos} !== {32'd6, 32'd1, 32'd5, 32'd6}) begin
      mismatched++; $display("FAIL mem_timing: busy=%0d memwe_n=%0d memwe_at=%0d wb_at=%0d required 6 1 5 6",
                             cyc, mem_n, mem_pos, wb_pos);
    end
    compared++;
    if ({bus.busy, bus.cycle_cnt, bus.instr_cnt} !== {1'b0, 6'd6, 6'd1}) begin
      mismatched++; $display("FAIL mem_counts: busy=%b cyc=%0d ins=%0d required 0 6 1",
                             bus.busy, bus.cycle_cnt, bus.instr_cnt);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    do_reset();
    bus.op = 16'h0B0B; bus.dec_pcwe = 1'b1; bus.dec_regwe = 1'b1; bus.step = 1'b1;
    push_exp(16'h0B0B, 1'b1, 1'b1);
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.pcwe, bus.pcinc} !== 2'b00) begin
      mismatched++; $display("FAIL br_exec: pcwe/pcinc=%b required 00", {bus.pcwe, bus.pcinc});
    end
    @(negedge clk); // WB
    compared++;
    if (sb.size() == 0) begin
      mismatched++; $display("FAIL br_wb: scoreboard empty at WB");
    end else begin
      e = sb.pop_front();
      if ({bus.ir, bus.regwe, bus.pcwe, bus.pcinc} !== {e.ir, e.regwe, e.pcwe, e.pcinc}) begin
        mismatched++; $display("FAIL br_wb: ir=%h regwe=%b pcwe=%b pcinc=%b required %h %b %b %b",
                               bus.ir, bus.regwe, bus.pcwe, bus.pcinc, e.ir, e.regwe, e.pcwe, e.pcinc);
      end
    end
    @(negedge clk);
    compared++;
    if ({bus.pcwe, bus.pcinc, bus.busy} !== 3'b000) begin
      mismatched++; $display("FAIL br_after: pcwe=%b pcinc=%b busy=%b required 0 0 0", bus.pcwe, bus.pcinc, bus.busy);
    end
  endtask

  task automatic test_halt_req();
    exp_t e;
    do_reset();
    bus.op = 16'h2222; bus.dec_regwe = 1'b1; bus.run = 1'b1;
    push_exp(16'h2222, 1'b1, 1'b0);
    @(negedge clk); bus.run = 1'b0;       // FETCH
    @(negedge clk); bus.halt_req = 1'b1;  // EXEC
    @(negedge clk); bus.halt_req = 1'b0;  // WB
    compared++;
    if (sb.size() == 0) begin
      mismatched++; $display("FAIL hreq_wb: scoreboard empty at WB");
    end else begin
      e = sb.pop_front();
      if ({bus.ir, bus.regwe, bus.pcinc} !== {e.ir, e.regwe, e.pcinc}) begin
        mismatched++; $display("FAIL hreq_wb: ir=%h regwe=%b pcinc=%b required %h %b %b",
                               bus.ir, bus.regwe, bus.pcinc, e.ir, e.regwe, e.pcinc);
      end
    end
    @(negedge clk);
    compared++;
    if ({bus.busy, bus.instr_cnt} !== {1'b0, 6'd1}) begin
      mismatched++; $display("FAIL hreq_idle: busy=%b ins=%0d required 0 1", bus.busy, bus.instr_cnt);
    end
    bus.halt_req = 1'b1;                  // in IDLE: must not stick
    @(negedge clk);
    bus.halt_req = 1'b0; bus.op = 16'h3333; bus.run = 1'b1;
    push_exp(16'h3333, 1'b1, 1'b0);
    @(negedge clk); bus.run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) e = sb.pop_front();
    @(negedge clk);
    compared++;
    if (bus.busy !== 1'b1) begin
      mismatched++; $display("FAIL hreq_ignored_idle: busy=%b required 1", bus.busy);
    end
    push_exp(16'h3333, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);                       // WB: pulse halt_req here
    bus.halt_req = 1'b1;
    compared++;
    if (sb.size() == 0) begin
      mismatched++; $display("FAIL hreq_wb2: scoreboard empty at WB");
    end else begin
      e = sb.pop_front();
      if ({bus.ir, bus.pcinc} !== {e.ir, e.pcinc}) begin
        mismatched++; $display("FAIL hreq_wb2: ir=%h pcinc=%b required %h %b", bus.ir, bus.pcinc, e.ir, e.pcinc);
      end
    end
    @(negedge clk);
    bus.halt_req = 1'b0;
    compared++;
    if ({bus.busy, bus.instr_cnt} !== {1'b0, 6'd3}) begin
      mismatched++; $display("FAIL hreq_same_wb: busy=%b ins=%0d required 0 3", bus.busy, bus.instr_cnt);
    end
  endtask

  task automatic test_halt_opcode();
    int bad = 0;
    do_reset();
    bus.op = 16'hFFFF; bus.dec_regwe = 1'b1; bus.dec_memwe = 1'b1; bus.run = 1'b1;
    @(negedge clk);
    @(negedge clk); // EXEC with ir=FFFF
    compared++;
    if ({bus.ir, bus.zfwe, bus.busy} !== {16'hFFFF, 1'b0, 1'b1}) begin
      mismatched++; $display("FAIL halt_exec: ir=%h zfwe=%b busy=%b required FFFF 0 1", bus.ir, bus.zfwe, bus.busy);
    end
    @(negedge clk);
    compared++;
    if ({bus.halted, bus.busy} !== 2'b10) begin
      mismatched++; $display("FAIL halt_enter: halted=%b busy=%b required 1 0", bus.halted, bus.busy);
    end
    bus.step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.halt_req = i[0];
      @(negedge clk);
      if ({bus.halted, bus.busy, bus.pcwe, bus.pcinc, bus.regwe, bus.memwe, bus.zfwe} !== 7'b1000000 ||
          bus.cycle_cnt !== 6'd2 || bus.instr_cnt !== 6'd0) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++; $display("FAIL halt_hold: %0d bad cycles required 0 (cyc=%0d ins=%0d)", bad, bus.cycle_cnt, bus.instr_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    bus.op = 16'h00C3; bus.dec_memwe = 1'b1; bus.run = 1'b1;
    @(negedge clk); bus.run = 1'b0;
    repeat (4) @(negedge clk); // cycle 5: last MEM cycle
    compared++;
    if (bus.memwe !== 1'b1) begin
      mismatched++; $display("FAIL rmem_pre: memwe=%b required 1", bus.memwe);
    end
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if ({bus.memwe, bus.busy, bus.ir, bus.cycle_cnt, bus.instr_cnt} !== 30'h0) begin
      mismatched++; $display("FAIL rmem_async: memwe=%b busy=%b ir=%h cyc=%0d ins=%0d required all 0",
                             bus.memwe, bus.busy, bus.ir, bus.cycle_cnt, bus.instr_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.op = 16'h0001; bus.run = 1'b1;
    repeat (250) @(negedge clk);
    compared++;
    if ({bus.cycle_cnt, bus.instr_cnt} !== {6'd63, 6'd63}) begin
      mismatched++; $display("FAIL saturate: cyc=%0d ins=%0d required 63 63", bus.cycle_cnt, bus.instr_cnt);
    end
    bus.run = 1'b0; bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL saturate_stop: busy=%b required 0", bus.busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_run_single();
    test_step_mem();
    test_branch();
    test_halt_req();
    test_halt_opcode();
    test_reset_mid_mem();
    test_saturation();
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
